// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers one result per functional unit and publishes at most one per cycle on the CDB, round-robin.
module cdb_arbiter #(
  parameter int TAG_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [3:0]            src_valid,
  output logic [3:0]            src_ready,
  input  logic [4*TAG_W-1:0]    src_tag,
  input  logic [4*DATA_W-1:0]   src_data,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [DATA_W-1:0]     cdb_data,
  output logic [1:0]            cdb_src
);
  logic [3:0]        hold_valid, grant, accept;
  logic [TAG_W-1:0]  hold_tag [4];
  logic [DATA_W-1:0] hold_data [4];
  logic [1:0]        rr_ptr, win;
  logic              any;
  // scanning offsets downward leaves the nearest set bit from rr_ptr as winner
  always_comb begin
    win = rr_ptr;
    for (int k = 3; k >= 0; k--) win = hold_valid[rr_ptr + 2'(k)] ? rr_ptr + 2'(k) : win;
    any = |hold_valid && !flush;
    grant = any ? 4'b1 << win : 4'b0;
    src_ready = (reset || flush) ? 4'b0 : ~hold_valid | grant;
    accept = src_valid & src_ready;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hold_valid <= '0;
      rr_ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_tag <= '0;
      cdb_data <= '0;
      cdb_src <= '0;
    end else begin
      hold_valid <= flush ? 4'b0 : accept | (hold_valid & ~grant);
      cdb_valid <= any;
      if (any) begin
        cdb_tag <= hold_tag[win];
        cdb_data <= hold_data[win];
        cdb_src <= win;
        rr_ptr <= win + 2'd1;
      end
    end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (accept[i]) begin
        hold_tag[i] <= src_tag[i*TAG_W +: TAG_W];
        hold_data[i] <= src_data[i*DATA_W +: DATA_W];
      end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random stimulus against a behavioural model, with a queue-based CDB scoreboard.
module tb_cdb_arbiter;
  localparam int TAG_W = 6;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [1:0]        src;
  } pub_t;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic [3:0] src_valid = '0, src_ready;
  logic [4*TAG_W-1:0] src_tag = '0;
  logic [4*DATA_W-1:0] src_data = '0;
  logic cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [1:0] cdb_src;
  int total = 0, bad = 0;
  pub_t exp_q [$];
  logic [TAG_W-1:0] tg [4];
  logic [DATA_W-1:0] dt [4];
  bit mv [4];
  logic [TAG_W-1:0] mtag [4];
  logic [DATA_W-1:0] mdat [4];
  int ptr = 0;
  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_data(src_data), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: one expected publication per cycle at most, popped right after the edge that should show it
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0) begin
        pub_t e;
        e = exp_q.pop_front();
        chk("cdb_valid", 64'(cdb_valid), 64'd1);
        chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
        chk("cdb_data", 64'(cdb_data), 64'(e.data));
        chk("cdb_src", 64'(cdb_src), 64'(e.src));
      end else chk("cdb_idle", 64'(cdb_valid), 64'd0);
    end
  end
  task automatic model_reset();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    ptr = 0;
    exp_q.delete();
  endtask
  // one cycle: drive inputs after the falling edge, check ready, advance the model to the next rising edge
  task automatic step(input logic [3:0] v, input logic f);
    int w;
    logic [3:0] er;
    @(negedge clk);
    src_valid = v;
    flush = f;
    for (int i = 0; i < 4; i++) begin
      src_tag[i*TAG_W +: TAG_W] = tg[i];
      src_data[i*DATA_W +: DATA_W] = dt[i];
    end
    #1;
    w = -1;
    for (int off = 3; off >= 0; off--) if (mv[(ptr + off) % 4]) w = (ptr + off) % 4;
    if (f) w = -1;
    for (int i = 0; i < 4; i++) er[i] = !f && (!mv[i] || w == i);
    chk("src_ready", 64'(src_ready), 64'(er));
    if (f) for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    else begin
      if (w >= 0) begin
        exp_q.push_back('{tag: mtag[w], data: mdat[w], src: 2'(w)});
        mv[w] = 1'b0;
        ptr = (w + 1) % 4;
      end
      for (int i = 0; i < 4; i++)
        if (v[i] && er[i]) begin
          mv[i] = 1'b1;
          mtag[i] = tg[i];
          mdat[i] = dt[i];
        end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    src_valid = '0;
    flush = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", 64'(src_ready), 64'd0);
    chk("rst_cdb", {cdb_valid, 24'(cdb_tag), 32'(cdb_data), 2'(cdb_src)}, 64'd0);
    @(posedge clk);
    #3 reset = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      tg[i] = '0;
      dt[i] = '0;
    end
    model_reset();
    #1;
    chk("init_cdb", {cdb_valid, 24'(cdb_tag), 32'(cdb_data), 2'(cdb_src)}, 64'd0);
    chk("init_ready", 64'(src_ready), 64'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    tg[0] = 6'h05;
    dt[0] = 32'hDEADBEEF;
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tg[i] = 6'(i + 1);
      dt[i] = 32'h1000 + 32'(i);
    end
    step(4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) step(4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tg[3] = 6'(10 + k);
      dt[3] = 32'hD1D0 + 32'(k);
      step(4'b1000, 1'b0);
    end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tg[0] = 6'(20 + k);
      dt[0] = 32'hA000 + 32'(k);
      tg[2] = 6'h30;
      dt[2] = 32'hC0DE;
      step(k == 0 ? 4'b0101 : 4'b0001, 1'b0);
    end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    tg[1] = 6'd7;
    tg[2] = 6'd8;
    dt[1] = 32'h77;
    dt[2] = 32'h88;
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tg[i] = 6'(40 + i);
      dt[i] = 32'hB000 + 32'(i);
    end
    step(4'b0111, 1'b0);
    step(4'b0000, 1'b0);
    do_reset();
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        tg[i] = 6'($urandom);
        dt[i] = $urandom;
      end
      step(4'($urandom), $urandom_range(0, 15) == 0);
    end
    for (int k = 0; k < 6; k++) step(4'b0000, 1'b0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
